// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Also holds the legality rule for memory accesses.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Only meaningful for memory ops: read+write together, an illegal size,
    // or an address that is not naturally aligned to the access size.
    function automatic logic is_bad_access(input logic  rd,
                                           input logic  wr,
                                           input size_t sz,
                                           input logic [1:0] off);
        return (rd & wr)
             | (sz == SZ_ILL)
             | ((sz == SZ_HALF) & off[0])
             | ((sz == SZ_WORD) & (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication and byte enables,
// plus load lane extraction with sign/zero extension. Lanes are little-endian.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_st_size,
    input  logic [1:0]        i_st_off,
    input  logic [DATA_W-1:0] i_st_data,
    output logic [3:0]        o_st_be,
    output logic [DATA_W-1:0] o_st_wdata,
    input  logic [1:0]        i_ld_size,
    input  logic [1:0]        i_ld_off,
    input  logic              i_ld_unsigned,
    input  logic [DATA_W-1:0] i_ld_rdata,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [DATA_W-1:0] w_ld_shifted;

    always_comb begin
        o_st_be    = BE_W;
        o_st_wdata = i_st_data;
        case (size_t'(i_st_size))
            SZ_BYTE: begin
                o_st_be    = BE_B << i_st_off;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_st_be    = BE_H << i_st_off;
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be    = BE_W;
                o_st_wdata = i_st_data;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign w_ld_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (size_t'(i_ld_size))
            SZ_BYTE: begin
                if (i_ld_unsigned)
                    o_ld_data = {24'b0, w_ld_shifted[7:0]};
                else
                    o_ld_data = {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            end
            SZ_HALF: begin
                if (i_ld_unsigned)
                    o_ld_data = {16'b0, w_ld_shifted[15:0]};
                else
                    o_ld_data = {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            end
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_m.sv
// Memory-stage load/store unit: accepts EX results, issues one data-memory
// access at a time, stalls upstream while it is outstanding, and returns writeback data.
module lsu_m
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              flush,
    output logic              stall_o,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              misalign_exc
);

    state_t              r_state;
    logic                r_we;
    logic [3:0]          r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_off;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [REG_W-1:0]    r_rd;
    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_data;
    logic [REG_W-1:0]    r_wb_rd;
    logic                r_exc;

    logic                w_accept;
    logic                w_mem_op;
    logic                w_bad;
    logic                w_issue;
    logic                w_exc;
    logic                w_passthru;
    logic                w_done;
    logic [3:0]          w_st_be;
    logic [DATA_W-1:0]   w_st_wdata;
    logic [DATA_W-1:0]   w_ld_data;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_st_size     (ex_size),
        .i_st_off      (ex_addr[1:0]),
        .i_st_data     (ex_wdata),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_off      (r_off),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    assign w_accept   = (r_state == ST_IDLE) & ex_valid & ~flush;
    assign w_mem_op   = ex_mem_read | ex_mem_write;
    assign w_bad      = is_bad_access(ex_mem_read, ex_mem_write, size_t'(ex_size), ex_addr[1:0]);
    assign w_issue    = w_accept & w_mem_op & ~w_bad;
    assign w_exc      = w_accept & w_mem_op & w_bad;
    assign w_passthru = w_accept & ~w_mem_op;
    assign w_done     = (r_state == ST_REQ) & mem_ready;

    // The issuing cycle stalls combinationally so EX holds until the access retires.
    assign stall_o      = (r_state == ST_REQ) | w_issue;
    assign mem_req      = (r_state == ST_REQ);
    assign mem_we       = r_we & (r_state == ST_REQ);
    assign mem_be       = r_be;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;
    assign wb_rd        = r_wb_rd;
    assign misalign_exc = r_exc;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_issue)   r_state <= ST_REQ;
                ST_REQ:  if (mem_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request fields are captured once at issue and held for the whole access.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_be       <= 4'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_off      <= 2'b0;
            r_size     <= 2'b0;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
        end else if (w_issue) begin
            r_we       <= ex_mem_write;
            r_be       <= ex_mem_write ? w_st_be : BE_W;
            r_addr     <= {ex_addr[ADDR_W-1:2], 2'b00};
            r_wdata    <= ex_mem_write ? w_st_wdata : '0;
            r_off      <= ex_addr[1:0];
            r_size     <= ex_size;
            r_unsigned <= ex_unsigned;
            r_rd       <= ex_rd;
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
            r_exc      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_exc      <= w_exc;
            if (w_passthru) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= DATA_W'(ex_addr);
                r_wb_rd    <= ex_rd;
            end else if (w_done & ~r_we) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= w_ld_data;
                r_wb_rd    <= r_rd;
            end
        end
    end

endmodule

// File: tb/tb_lsu_m.sv
// Scoreboard bench for lsu_m: a byte-addressed memory model predicts every
// memory request and writeback; monitors compare whatever the unit presents.
module tb_lsu_m;

    logic        ref_clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, flush;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_o, mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, misalign_exc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    typedef struct {
        bit          isExc;
        logic [31:0] data;
        logic [4:0]  rd;
        int          cycle;
    } evT;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } reqT;

    evT          evQ[$];
    reqT         reqQ[$];
    logic [7:0]  memBytes [logic [31:0]];
    int          checks = 0;
    int          passes = 0;
    int          cycle = 0;
    int          readyDelay = 0;
    bit          idleNoise = 1'b0;

    lsu_m #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) dut (
        .ref_clk      (ref_clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .stall_o      (stall_o),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .misalign_exc (misalign_exc)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    function automatic logic [7:0] memRead(input logic [31:0] a);
        if (memBytes.exists(a)) return memBytes[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] readWord(input logic [31:0] a);
        return {memRead(a + 32'd3), memRead(a + 32'd2), memRead(a + 32'd1), memRead(a)};
    endfunction

    // Memory responder: answers after readyDelay wait cycles, may toggle ready while idle.
    int waitCnt = 0;
    always begin
        @(posedge ref_clk);
        #1;
        if (mem_req) begin
            if (waitCnt >= readyDelay) begin
                mem_ready = 1'b1;
                mem_rdata = readWord(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                waitCnt++;
            end
        end else begin
            waitCnt   = 0;
            mem_ready = idleNoise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Request monitor: every REQ cycle must show the predicted, stable request.
    always @(negedge ref_clk) begin
        reqT r;
        if (rst_n && mem_req) begin
            if (reqQ.size() == 0) begin
                checkOutput("unexpected mem_req", 32'(mem_req), 32'd0);
            end else begin
                r = reqQ[0];
                checkOutput("mem_we", 32'(mem_we), 32'(r.we));
                checkOutput("mem_be", 32'(mem_be), 32'(r.be));
                checkOutput("mem_addr", mem_addr, r.addr);
                if (r.we) checkOutput("mem_wdata", mem_wdata, r.wdata);
                checkOutput("stall during req", 32'(stall_o), 32'd1);
                if (mem_ready) void'(reqQ.pop_front());
            end
        end
    end

    // Result monitor: writebacks and exceptions in issue order with exact latency.
    always @(negedge ref_clk) begin
        evT e;
        if (rst_n) begin
            if (wb_valid && misalign_exc) checkOutput("wb/exc overlap", 32'd1, 32'd0);
            if (wb_valid || misalign_exc) begin
                if (evQ.size() == 0) begin
                    checkOutput("unexpected output event", {30'b0, wb_valid, misalign_exc}, 32'd0);
                end else begin
                    e = evQ.pop_front();
                    checkOutput("event kind exc", 32'(misalign_exc), 32'(e.isExc));
                    if (!e.isExc) begin
                        checkOutput("wb_data", wb_data, e.data);
                        checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
                    end
                    checkOutput("event latency", 32'(cycle), 32'(e.cycle));
                end
            end
        end
    end

    // Called just after a rising edge with the unit idle; returns at the same phase.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rdIdx, input bit fl, input int delay,
                                 input bit junk);
        evT          e;
        reqT         r;
        int          n, off, stallCnt;
        bit          memOp, bad, expStall, done;
        logic [31:0] val;
        readyDelay   = delay;
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_size      = sz;
        ex_unsigned  = uns;
        ex_addr      = addr;
        ex_wdata     = wdata;
        ex_rd        = rdIdx;
        flush        = fl;
        memOp    = rd || wr;
        n        = 1 << sz;
        off      = int'(addr[1:0]);
        bad      = memOp && ((rd && wr) || (sz == 2'd3) || ((addr % n) != 0));
        expStall = !fl && memOp && !bad;
        if (!fl) begin
            if (!memOp) begin
                e = '{isExc: 1'b0, data: addr, rd: rdIdx, cycle: cycle + 1};
                evQ.push_back(e);
            end else if (bad) begin
                e = '{isExc: 1'b1, data: 32'd0, rd: 5'd0, cycle: cycle + 1};
                evQ.push_back(e);
            end else begin
                r.we    = wr;
                r.addr  = addr & ~32'h3;
                r.wdata = 32'd0;
                if (wr) begin
                    r.be = 4'(((1 << n) - 1) << off);
                    for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wdata[8*(k % n) +: 8];
                    for (int i = 0; i < n; i++) memBytes[addr + i] = wdata[8*i +: 8];
                end else begin
                    r.be = 4'hF;
                    val  = 32'd0;
                    for (int i = 0; i < n; i++) val = val | (32'(memRead(addr + i)) << (8 * i));
                    if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
                    e = '{isExc: 1'b0, data: val, rd: rdIdx, cycle: cycle + 2 + delay};
                    evQ.push_back(e);
                end
                reqQ.push_back(r);
            end
        end
        @(negedge ref_clk);
        checkOutput("stall at accept", 32'(stall_o), 32'(expStall));
        @(posedge ref_clk);
        #1;
        if (!expStall) begin
            ex_valid = 1'b0;
            flush    = 1'b0;
            return;
        end
        stallCnt = 1;
        done     = 1'b0;
        for (int g = 0; g < 60 && !done; g++) begin
            if (!stall_o) begin
                done = 1'b1;
            end else begin
                stallCnt++;
                if (junk) begin
                    ex_valid     = 1'b1;
                    flush        = 1'b1;
                    ex_mem_read  = 1'($urandom_range(0, 1));
                    ex_mem_write = 1'($urandom_range(0, 1));
                    ex_addr      = $urandom;
                    ex_wdata     = $urandom;
                end else begin
                    ex_valid = 1'b0;
                end
                @(posedge ref_clk);
                #1;
            end
        end
        ex_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("stall released", 32'(done), 32'd1);
        checkOutput("stall cycles", 32'(stallCnt), 32'(2 + delay));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " stall_o"}, 32'(stall_o), 32'd0);
        checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, " mem_be"}, 32'(mem_be), 32'd0);
        checkOutput({tag, " mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
        checkOutput({tag, " wb_data"}, wb_data, 32'd0);
        checkOutput({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
        checkOutput({tag, " misalign_exc"}, 32'(misalign_exc), 32'd0);
    endtask

    task automatic resetMidAccess();
        reqT r;
        readyDelay   = 1000;
        idleNoise    = 1'b0;
        ex_valid     = 1'b1;
        ex_mem_read  = 1'b1;
        ex_mem_write = 1'b0;
        ex_size      = 2'd2;
        ex_unsigned  = 1'b0;
        ex_addr      = 32'h0000_5000;
        ex_rd        = 5'd9;
        flush        = 1'b0;
        r = '{we: 1'b0, be: 4'hF, addr: 32'h0000_5000, wdata: 32'd0};
        reqQ.push_back(r);
        @(negedge ref_clk);
        checkOutput("reset test stall at accept", 32'(stall_o), 32'd1);
        @(posedge ref_clk);
        #1;
        ex_valid = 1'b0;
        @(posedge ref_clk);
        #1;
        @(negedge ref_clk);
        checkOutput("reset test mem_req before reset", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-access reset");
        reqQ.delete();
        @(posedge ref_clk);
        #1;
        rst_n      = 1'b1;
        readyDelay = 0;
        idleNoise  = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_size      = 2'd0;
        ex_unsigned  = 1'b0;
        ex_addr      = 32'd0;
        ex_wdata     = 32'd0;
        ex_rd        = 5'd0;
        flush        = 1'b0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'd0;
        repeat (3) @(posedge ref_clk);
        #1;
        checkResetOutputs("reset");
        rst_n     = 1'b1;
        idleNoise = 1'b1;

        $display("[TB] directed loads: lb/lbu at 0x1003");
        memBytes[32'h1000] = 8'h34;
        memBytes[32'h1001] = 8'h12;
        memBytes[32'h1002] = 8'hFF;
        memBytes[32'h1003] = 8'h80;
        applyStimulus(1, 0, 2'd0, 0, 32'h1003, 32'd0, 5'd3, 0, 0, 0);
        applyStimulus(1, 0, 2'd0, 1, 32'h1003, 32'd0, 5'd4, 0, 0, 0);

        $display("[TB] directed store: sh at 0x2002 with delayed ready");
        applyStimulus(0, 1, 2'd1, 0, 32'h2002, 32'hDEAD_BEEF, 5'd0, 0, 3, 0);
        applyStimulus(1, 0, 2'd2, 0, 32'h2000, 32'd0, 5'd5, 0, 1, 0);

        $display("[TB] directed exceptions");
        applyStimulus(1, 0, 2'd2, 0, 32'h3002, 32'd0, 5'd1, 0, 0, 0);
        applyStimulus(1, 0, 2'd1, 0, 32'h3001, 32'd0, 5'd1, 0, 0, 0);
        applyStimulus(1, 0, 2'd3, 0, 32'h3000, 32'd0, 5'd1, 0, 0, 0);
        applyStimulus(1, 1, 2'd2, 0, 32'h3000, 32'd0, 5'd1, 0, 0, 0);

        $display("[TB] directed passthrough and flush");
        applyStimulus(0, 0, 2'd0, 0, 32'h0000_002A, 32'd0, 5'd7, 0, 0, 0);
        applyStimulus(0, 0, 2'd0, 0, 32'h0000_002A, 32'd0, 5'd7, 1, 0, 0);
        applyStimulus(0, 1, 2'd2, 0, 32'h0000_7000, 32'h1111_2222, 5'd0, 1, 0, 0);

        $display("[TB] back-to-back sw, lw, add");
        applyStimulus(0, 1, 2'd2, 0, 32'h4000, 32'hCAFE_F00D, 5'd0, 0, 0, 1);
        applyStimulus(1, 0, 2'd2, 0, 32'h4000, 32'd0, 5'd10, 0, 0, 0);
        applyStimulus(0, 0, 2'd0, 0, 32'h0000_1234, 32'd0, 5'd11, 0, 0, 0);

        $display("[TB] reset during an outstanding access");
        resetMidAccess();
        applyStimulus(0, 0, 2'd0, 0, 32'h0000_0055, 32'd0, 5'd12, 0, 0, 0);
        applyStimulus(1, 0, 2'd1, 1, 32'h1002, 32'd0, 5'd13, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 200; i++) begin
            int          kind;
            bit          rdB, wrB;
            logic [1:0]  sz;
            kind = int'($urandom_range(0, 9));
            rdB  = (kind <= 3) || (kind == 9);
            wrB  = (kind >= 4 && kind <= 6) || (kind == 9);
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(rdB, wrB, sz, 1'($urandom_range(0, 1)),
                          32'h6000 + 32'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge ref_clk);
        #1;
        checkOutput("events outstanding", 32'(evQ.size()), 32'd0);
        checkOutput("requests outstanding", 32'(reqQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
